// File: rtl/seq_frame_tx.sv
// -----------------------------------------------------------------------------
// seq_frame_tx
// Serial frame transmitter. Accepts one parallel payload word through a
// valid/ready handshake and sends it one bit per clock as:
//   sync pattern (MSB-first) -> payload (MSB-first) -> optional even parity
//   -> idle gap (out=0)
// A downstream recognizer can lock onto the sync header and sample the payload.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   start_valid  request to send data_in
//   data_in      payload word, sampled only on an accepted handshake
//   start_ready  high only in IDLE; a frame is accepted on valid && ready
//   out          serial bit stream
//   out_valid    out carries a frame bit (sync, data or parity)
//   busy         a frame (including its gap) is in progress
//   done         one-cycle pulse in the first IDLE cycle after a frame
// -----------------------------------------------------------------------------
module seq_frame_tx #(
    parameter int                DATA_W       = 8,
    parameter int                SYNC_W       = 3,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 3'b101,
    parameter int                PARITY_EN    = 1,
    parameter int                GAP_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              start_ready,
    output logic              out,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    // The counter must reach the last index of the longest phase.
    localparam int MAX_A   = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int MAX_LEN = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PARITY,
        GAP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data_sr;
    logic [SYNC_W-1:0] sync_sr;
    logic              parity_bit;
    logic              done_q;
    logic              accept;

    assign accept = start_valid && (state == IDLE);

    // Next-state and decoded serial outputs.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // through the case statement can leave it unassigned and infer a latch.
        state_next = state;
        out        = 1'b0;
        out_valid  = 1'b0;

        case (state)
            IDLE: begin
                if (start_valid) state_next = SYNC;
            end
            SYNC: begin
                out       = sync_sr[SYNC_W-1];
                out_valid = 1'b1;
                if (cnt == SYNC_LAST) state_next = DATA;
            end
            DATA: begin
                out       = data_sr[DATA_W-1];
                out_valid = 1'b1;
                if (cnt == DATA_LAST) begin
                    if (PARITY_EN != 0)     state_next = PARITY;
                    else if (GAP_CYCLES > 0) state_next = GAP;
                    else                     state_next = IDLE;
                end
            end
            PARITY: begin
                out       = parity_bit;
                out_valid = 1'b1;
                state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (cnt == GAP_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state: state, phase counter and the done pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state <= state_next;
            // Counter restarts on every state change and rests at zero in IDLE.
            if ((state_next != state) || (state == IDLE)) cnt <= '0;
            else                                          cnt <= cnt + CNT_W'(1);
            // Pulse lands in the first IDLE cycle after any frame phase.
            done_q <= (state != IDLE) && (state_next == IDLE);
        end
    end

    // Frame datapath: loaded on accept, shifted while its phase is active.
    // NOTE: these registers are deliberately left out of reset; they are
    // always reloaded on accept before any state reads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_sr    <= data_in;
            sync_sr    <= SYNC_PATTERN;
            parity_bit <= ^data_in;
        end else begin
            if (state == SYNC) sync_sr <= sync_sr << 1;
            if (state == DATA) data_sr <= data_sr << 1;
        end
    end

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = done_q;

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
Serial frame transmitter and generator for the bit-serial recognition path. It accepts a parallel word through a valid/ready handshake. It then drives one bit per clock onto a serial line in this order: fixed sync pattern, payload MSB-first, optional even-parity bit, then an idle gap. A downstream pattern recognizer can lock onto the sync header and sample the payload that follows.

Parameters:
DATA_W, 8, payload width in bits (1..32)
SYNC_W, 3, sync pattern length in bits (1..8)
SYNC_PATTERN, 3'b101, sync bits, sent MSB-first
PARITY_EN, 1, 1 = append even-parity bit after payload; 0 = no parity bit
GAP_CYCLES, 2, idle cycles (out=0) after each frame (0..15)

Ports:
clk  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start_valid  input  1  request to send data_in
data_in  input  DATA_W  payload word, sampled only on handshake
start_ready  output  1  block can accept a frame (high only in IDLE)
out  output  1  serial bit stream
out_valid  output  1  out carries a frame bit (sync, data or parity)
busy  output  1  frame in progress (any state except IDLE)
done  output  1  one-cycle pulse: frame (including gap) completed

Behaviour:
- Interface is fixed as follows: one clock; reset is synchronous and active-high; clock port named clk, reset port named reset.
- All outputs are registered or decoded from state. No combinational path exists from start_valid or data_in to any output.
- Reset values (after any edge with reset=1): state=IDLE, out=0, out_valid=0, busy=0, done=0, start_ready=1. Reset has priority over the handshake in the same cycle.
- Handshake: accept when start_valid && start_ready at a rising edge. At that edge, data_in is latched into the shift register and parity is computed (XOR of all data bits). Later changes to data_in are ignored until the next accept.
- start_valid while busy is ignored. No queueing, no error flag.
- FSM states: IDLE, SYNC, DATA, PARITY, GAP.
  - IDLE: out=0, out_valid=0, busy=0, start_ready=1. On accept, go to SYNC with bit counter=0.
  - SYNC: out=SYNC_PATTERN[SYNC_W-1-cnt], out_valid=1. After SYNC_W cycles, go to DATA.
  - DATA: out=shift register MSB, shift left each cycle, out_valid=1. After DATA_W cycles, go to PARITY if PARITY_EN, else GAP.
  - PARITY: out=parity bit, so that data plus parity has an even count of ones. out_valid=1. Lasts 1 cycle, then go to GAP.
  - GAP: out=0, out_valid=0, busy=1. Lasts GAP_CYCLES cycles, then go to IDLE. If GAP_CYCLES=0, go directly to IDLE and never enter GAP.
- Latency: with accept at edge E0, the first sync bit appears on out in the cycle after E0. Frame length is L = SYNC_W + DATA_W + PARITY_EN + GAP_CYCLES. busy is high for exactly L cycles.
- done=1 for exactly one cycle: the first IDLE cycle after a frame. start_ready is also 1 in that cycle, so a new accept there gives back-to-back frames with no dead cycle beyond the gap.
- Reset mid-frame: at the next edge the block returns to IDLE with reset values. The frame is truncated, no done pulse is produced, and latched data is discarded.
- Counter width covers max(SYNC_W, DATA_W, GAP_CYCLES). The counter clears on every state change.

Test Plan:
- Reset, then hold start_valid=0 for 5 cycles -> out=0, out_valid=0, busy=0, start_ready=1, done=0 throughout.
- Defaults, accept data_in=8'hA5 -> out over cycles 1..11: 1,0,1, 1,0,1,0,0,1,0,1. Cycle 12: parity=0 with out_valid=1. Cycles 13-14: out=0, out_valid=0. Cycle 15: done=1, start_ready=1.
- Accept 8'h01, then drive data_in=8'hFF and start_valid=1 through the whole frame -> payload is 0000_0001, parity=1, exactly one frame sent. A second frame (8'hFF, parity 0) is accepted in the done cycle and its sync starts the next cycle.
- Assert reset for one cycle during the 4th payload bit -> next cycle out=0, out_valid=0, busy=0, start_ready=1, and no done pulse appears.
- PARITY_EN=0, GAP_CYCLES=0, accept 8'h3C -> 1,0,1,0,0,1,1,1,1,0,0 on cycles 1..11, then done=1 on cycle 12.
- Scoreboard loop: feed the out stream into the team's 101-recognizer model for 50 random back-to-back frames -> each frame is decoded as sync followed by the original payload, with correct parity.
